vend_sequencer: RTL and testbench
=================================

Name: vend_sequencer

Overview:
Transaction controller for the vending payment datapath. Accepts item selections, checks stock, and drives the payment block's state/curIndex/cancelled inputs. Sequences dispense and change-return handshakes and enforces payment and dispense timeouts. Sits between the keypad/inventory logic and the payment block.

Parameters:
NUM_ITEMS, 8, number of selectable items (index 0..NUM_ITEMS-1)
STOCK_W, 4, bits per item stock count
PAY_TIMEOUT, 1000, idle cycles allowed in PAY before auto-cancel
DISP_TIMEOUT, 200, cycles allowed for dispense_done before fault
TMR_W, 10, timer width; must hold max(PAY_TIMEOUT, DISP_TIMEOUT)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
select_valid  in  1  one-cycle selection strobe
select_index  in  4  requested item
stock_count  in  NUM_ITEMS*STOCK_W  packed per-item stock; item i at [i*STOCK_W +: STOCK_W]
coin_event  in  1  any coin accepted this cycle (restarts pay timer)
enough_money  in  1  payment block reports balance >= price
cancel_btn  in  1  customer cancel, level
dispense_done  in  1  inventory/dispense ack
change_done  in  1  change-return ack
state  out  2  00 IDLE, 01 PAY, 10 VEND, 11 RETURN
cur_index  out  4  latched selection
dispense_req  out  1  request to reduce inventory/dispense
cancel_req  out  1  request change return (drives payment cancelled)
sold_out  out  1  one-cycle pulse: rejected selection
fault  out  1  sticky dispense-timeout flag
vend_count  out  16  completed sales, saturating at 16'hFFFF

Behaviour:
- Reset (rst=0, async): state=IDLE, cur_index=0, all req/pulse outputs 0, fault=0, vend_count=0, timer=0. Reset mid-transaction aborts without any handshake.
- All outputs registered; state changes take effect the edge after the causing input.
- IDLE: select_valid with index<NUM_ITEMS and stock>0 -> latch cur_index, load timer=PAY_TIMEOUT, go PAY.
  - Index>=NUM_ITEMS or stock==0 -> sold_out=1 for exactly one cycle; stay IDLE, cur_index unchanged.
- PAY: timer decrements each cycle; coin_event reloads PAY_TIMEOUT (reload beats decrement).
  - select_valid ignored.
  - Priority: enough_money > cancel_btn > timer==0.
  - enough_money: go VEND, dispense_req=1, timer=DISP_TIMEOUT.
  - cancel_btn or timer reaches 0: go RETURN, cancel_req=1.
- VEND: dispense_req stays high until dispense_done=1.
  - Next edge: dispense_req=0, vend_count+1 (saturating), go RETURN with cancel_req=1 to return remaining balance.
  - Timer reaches 0 first: fault=1 (sticky until reset), dispense_req=0, no count, go RETURN.
  - cancel_btn ignored in VEND.
- RETURN: four-phase handshake.
  - cancel_req high until change_done=1; then cancel_req=0.
  - Stay in RETURN until change_done=0, then go IDLE.
  - change_done already high on entry: treated as ack on first cycle.
- The same four-phase rule applies to dispense: no new dispense_req until dispense_done has returned low; the IDLE->PAY path guarantees this.
- Timer is TMR_W bits and never wraps: it holds at 0.

Decomposition:
- vend_pkg: state encodings (ST_IDLE..ST_RETURN), default NUM_ITEMS, STOCK_W.
- One sub-module, vend_timer: loadable down-counter with load, load_val, and zero flag. Instantiated once and shared by PAY and VEND.

Test Plan:
- Select idx 3, stock 2, hold enough_money=1 two cycles later -> state 01 then 10, dispense_req=1; ack dispense_done -> req drops, vend_count=1, state 11, cancel_req=1; ack change_done, then release -> state 00.
- Select idx 5, stock 0; separately select idx 9 -> sold_out single-cycle pulse each time, state stays 00.
- PAY with no coins for PAY_TIMEOUT=16 -> cancel_req asserts at cycle 16, state 11; with a coin_event at cycle 10, timeout occurs at cycle 26.
- enough_money and cancel_btn asserted same cycle in PAY -> state 10, cancel_req stays 0.
- VEND with dispense_done never asserted, DISP_TIMEOUT=8 -> fault=1 after 8 cycles, dispense_req=0, vend_count unchanged, state 11.
- Assert rst low mid-VEND -> all outputs 0 immediately (asynchronous), state 00, fault 0.

Source files
------------

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encodings and default sizes for the vending sequencer
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_PAY    = 2'b01,
        ST_VEND   = 2'b10,
        ST_RETURN = 2'b11
    } state_t;

    localparam int DEF_NUM_ITEMS = 8;
    localparam int DEF_STOCK_W   = 4;
    localparam int SEL_W         = 4;
    localparam int VCNT_W        = 16;

endpackage

// File: rtl/vend_if.sv
// rtl/vend_if.sv - keypad/inventory/payment signal bundle around the sequencer
interface vend_if
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS = DEF_NUM_ITEMS,
    parameter int STOCK_W   = DEF_STOCK_W
);
    logic                         select_valid;
    logic [SEL_W-1:0]             select_index;
    logic [NUM_ITEMS*STOCK_W-1:0] stock_count;
    logic                         coin_event;
    logic                         enough_money;
    logic                         cancel_btn;
    logic                         dispense_done;
    logic                         change_done;
    logic [1:0]                   state;
    logic [SEL_W-1:0]             cur_index;
    logic                         dispense_req;
    logic                         cancel_req;
    logic                         sold_out;
    logic                         fault;
    logic [VCNT_W-1:0]            vend_count;

    modport slave (
        input  select_valid, select_index, stock_count, coin_event, enough_money,
               cancel_btn, dispense_done, change_done,
        output state, cur_index, dispense_req, cancel_req, sold_out, fault, vend_count
    );

    modport master (
        output select_valid, select_index, stock_count, coin_event, enough_money,
               cancel_btn, dispense_done, change_done,
        input  state, cur_index, dispense_req, cancel_req, sold_out, fault, vend_count
    );
endinterface

// File: rtl/vend_timer.sv
// rtl/vend_timer.sv - loadable down-counter that holds at zero, shared by PAY and VEND
module vend_timer #(
    parameter int TMR_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [TMR_W-1:0] o_count,
    output logic             o_zero
);
    logic [TMR_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);
endmodule

// File: rtl/vend_sequencer.sv
// rtl/vend_sequencer.sv - selection, payment, dispense and change-return transaction controller
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS    = DEF_NUM_ITEMS,
    parameter int STOCK_W      = DEF_STOCK_W,
    parameter int PAY_TIMEOUT  = 1000,
    parameter int DISP_TIMEOUT = 200,
    parameter int TMR_W        = 10
) (
    input  logic  clk,
    input  logic  rst,
    vend_if.slave bus
);
    state_t            r_state, w_state_nxt;
    logic [SEL_W-1:0]  r_cur_index, w_cur_nxt;
    logic              r_dispense_req, w_disp_nxt;
    logic              r_cancel_req, w_cancel_nxt;
    logic              r_sold_out, w_sold_nxt;
    logic              r_fault, w_fault_nxt;
    logic [VCNT_W-1:0] r_vend_count, w_vcnt_nxt;

    logic              w_stock_ok;
    logic              w_tmr_load, w_tmr_dec, w_tmr_zero, w_expire;
    logic [TMR_W-1:0]  w_tmr_val, w_tmr_count;

    vend_timer #(.TMR_W(TMR_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_count    (w_tmr_count),
        .o_zero     (w_tmr_zero)
    );

    // Out-of-range indices never match any item, so they fall out as sold-out.
    always_comb begin
        w_stock_ok = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if ((bus.select_index == SEL_W'(i)) &&
                (bus.stock_count[i*STOCK_W +: STOCK_W] != '0)) begin
                w_stock_ok = 1'b1;
            end
        end
    end

    // Expire on the edge that would bring the timer to zero.
    assign w_expire = w_tmr_zero || (w_tmr_count == TMR_W'(1));

    always_comb begin
        w_state_nxt  = r_state;
        w_cur_nxt    = r_cur_index;
        w_disp_nxt   = r_dispense_req;
        w_cancel_nxt = r_cancel_req;
        w_sold_nxt   = 1'b0;
        w_fault_nxt  = r_fault;
        w_vcnt_nxt   = r_vend_count;
        w_tmr_load   = 1'b0;
        w_tmr_val    = '0;
        w_tmr_dec    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.select_valid) begin
                    if (w_stock_ok) begin
                        w_cur_nxt   = bus.select_index;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = TMR_W'(PAY_TIMEOUT);
                        w_state_nxt = ST_PAY;
                    end else begin
                        w_sold_nxt = 1'b1;
                    end
                end
            end
            ST_PAY: begin
                w_tmr_dec = 1'b1;
                if (bus.enough_money) begin
                    w_state_nxt = ST_VEND;
                    w_disp_nxt  = 1'b1;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TMR_W'(DISP_TIMEOUT);
                end else if (bus.cancel_btn) begin
                    w_state_nxt  = ST_RETURN;
                    w_cancel_nxt = 1'b1;
                end else if (bus.coin_event) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TMR_W'(PAY_TIMEOUT);
                end else if (w_expire) begin
                    w_state_nxt  = ST_RETURN;
                    w_cancel_nxt = 1'b1;
                end
            end
            ST_VEND: begin
                w_tmr_dec = 1'b1;
                if (bus.dispense_done) begin
                    w_disp_nxt   = 1'b0;
                    w_cancel_nxt = 1'b1;
                    w_state_nxt  = ST_RETURN;
                    if (r_vend_count != {VCNT_W{1'b1}}) begin
                        w_vcnt_nxt = r_vend_count + 1'b1;
                    end
                end else if (w_expire) begin
                    w_fault_nxt  = 1'b1;
                    w_disp_nxt   = 1'b0;
                    w_cancel_nxt = 1'b1;
                    w_state_nxt  = ST_RETURN;
                end
            end
            ST_RETURN: begin
                if (r_cancel_req) begin
                    if (bus.change_done) begin
                        w_cancel_nxt = 1'b0;
                    end
                end else if (!bus.change_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_cur_index    <= '0;
            r_dispense_req <= 1'b0;
            r_cancel_req   <= 1'b0;
            r_sold_out     <= 1'b0;
            r_fault        <= 1'b0;
            r_vend_count   <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_cur_index    <= w_cur_nxt;
            r_dispense_req <= w_disp_nxt;
            r_cancel_req   <= w_cancel_nxt;
            r_sold_out     <= w_sold_nxt;
            r_fault        <= w_fault_nxt;
            r_vend_count   <= w_vcnt_nxt;
        end
    end

    assign bus.state        = r_state;
    assign bus.cur_index    = r_cur_index;
    assign bus.dispense_req = r_dispense_req;
    assign bus.cancel_req   = r_cancel_req;
    assign bus.sold_out     = r_sold_out;
    assign bus.fault        = r_fault;
    assign bus.vend_count   = r_vend_count;
endmodule

// File: tb/tb_vend_sequencer.sv
// tb/tb_vend_sequencer.sv - directed self-checking bench for vend_sequencer
module tb_vend_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    vend_if #(.NUM_ITEMS(8), .STOCK_W(4)) bus ();

    vend_sequencer #(
        .NUM_ITEMS(8), .STOCK_W(4), .PAY_TIMEOUT(16), .DISP_TIMEOUT(8), .TMR_W(10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {state, cur_index, dispense_req, cancel_req, sold_out, fault, vend_count}
    logic [25:0] obs;
    logic [25:0] exp_v;
    assign obs = {bus.state, bus.cur_index, bus.dispense_req, bus.cancel_req,
                  bus.sold_out, bus.fault, bus.vend_count};

    function automatic logic [25:0] pack(input logic [1:0] st, input logic [3:0] idx,
                                         input logic dr, input logic cr, input logic so,
                                         input logic f, input logic [15:0] vc);
        return {st, idx, dr, cr, so, f, vc};
    endfunction

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic select(input logic [3:0] idx);
        bus.select_valid = 1'b1;
        bus.select_index = idx;
        tick(1);
        bus.select_valid = 1'b0;
    endtask

    task automatic finish_return();
        bus.change_done = 1'b1;
        tick(1);
        bus.change_done = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        tick(2);
        exp_v = pack(2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_state: got %h want %h", obs, exp_v); end
        rst = 1'b1;
        tick(1);
    endtask

    task automatic test_vend();
        select(4'd3);
        exp_v = pack(2'b01, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL vend_pay_entry: got %h want %h", obs, exp_v); end
        tick(1);
        bus.enough_money = 1'b1;
        tick(1);
        bus.enough_money = 1'b0;
        exp_v = pack(2'b10, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL vend_enter: got %h want %h", obs, exp_v); end
        tick(1);
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL vend_hold_req: got %h want %h", obs, exp_v); end
        bus.dispense_done = 1'b1;
        tick(1);
        bus.dispense_done = 1'b0;
        exp_v = pack(2'b11, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1);
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL vend_done: got %h want %h", obs, exp_v); end
        tick(1);
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL vend_wait_change: got %h want %h", obs, exp_v); end
        bus.change_done = 1'b1;
        tick(1);
        exp_v = pack(2'b11, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL vend_change_ack: got %h want %h", obs, exp_v); end
        bus.change_done = 1'b0;
        tick(1);
        exp_v = pack(2'b00, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL vend_idle: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_sold_out();
        logic [3:0] idx_tab [2];
        idx_tab[0] = 4'd5;
        idx_tab[1] = 4'd9;
        for (int t = 0; t < 2; t++) begin
            select(idx_tab[t]);
            exp_v = pack(2'b00, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL sold_out_pulse idx %0d: got %h want %h", idx_tab[t], obs, exp_v); end
            tick(1);
            exp_v = pack(2'b00, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL sold_out_clear idx %0d: got %h want %h", idx_tab[t], obs, exp_v); end
        end
    endtask

    task automatic test_pay_timeout();
        select(4'd1);
        tick(15);
        exp_v = pack(2'b01, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL pay_before_timeout: got %h want %h", obs, exp_v); end
        tick(1);
        exp_v = pack(2'b11, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1);
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL pay_timeout_16: got %h want %h", obs, exp_v); end
        finish_return();
        select(4'd1);
        tick(9);
        bus.coin_event = 1'b1;
        tick(1);
        bus.coin_event = 1'b0;
        tick(15);
        exp_v = pack(2'b01, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL pay_coin_extend: got %h want %h", obs, exp_v); end
        tick(1);
        exp_v = pack(2'b11, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1);
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL pay_timeout_26: got %h want %h", obs, exp_v); end
        finish_return();
    endtask

    task automatic test_priority();
        select(4'd0);
        bus.enough_money = 1'b1;
        bus.cancel_btn   = 1'b1;
        tick(1);
        bus.enough_money = 1'b0;
        exp_v = pack(2'b10, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL priority_money_over_cancel: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_disp_timeout();
        tick(7);
        exp_v = pack(2'b10, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL disp_wait_cancel_ignored: got %h want %h", obs, exp_v); end
        tick(1);
        bus.cancel_btn = 1'b0;
        exp_v = pack(2'b11, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1);
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL disp_timeout_fault: got %h want %h", obs, exp_v); end
        finish_return();
        exp_v = pack(2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1);
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL fault_sticky: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_reset_mid_vend();
        select(4'd3);
        bus.enough_money = 1'b1;
        tick(1);
        bus.enough_money = 1'b0;
        exp_v = pack(2'b10, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1);
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL rst_pre_vend: got %h want %h", obs, exp_v); end
        #2;
        rst = 1'b0;
        #1;
        exp_v = pack(2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL rst_async_clear: got %h want %h", obs, exp_v); end
        @(negedge clk);
        rst = 1'b1;
        tick(2);
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL rst_stays_idle: got %h want %h", obs, exp_v); end
    endtask

    initial begin
        bus.select_valid  = 1'b0;
        bus.select_index  = 4'd0;
        bus.stock_count   = {4'd1, 4'd1, 4'd0, 4'd1, 4'd2, 4'd1, 4'd1, 4'd1};
        bus.coin_event    = 1'b0;
        bus.enough_money  = 1'b0;
        bus.cancel_btn    = 1'b0;
        bus.dispense_done = 1'b0;
        bus.change_done   = 1'b0;
        @(negedge clk);
        test_reset();
        test_vend();
        test_sold_out();
        test_pay_timeout();
        test_priority();
        test_disp_timeout();
        test_reset_mid_vend();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
